wptr_flow_ctrl: RTL



---
 rtl/wptr_flow_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/wptr_flow_ctrl.sv
// Write-side pointer and flow control for an async FIFO.
// Keeps the binary/Gray write pointer, the full flag, a sticky overflow flag
// and, when WPTR_LEVEL_EN is defined, the occupancy level and almost-full flag.
// Without WPTR_LEVEL_EN the level path is omitted and wLevel/wAFull read 0.
module wptr_flow_ctrl #(
  parameter int ADDR_SIZE    = 12,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rptr_s,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wFull,
  output logic                 wAFull,
  output logic [ADDR_SIZE:0]   wLevel,
  output logic                 wOvf
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Reject illegal parameterizations at elaboration.
  if (ADDR_SIZE < 2 || AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_param
    $error("wptr_flow_ctrl: illegal ADDR_SIZE/AFULL_MARGIN");
  end

  logic [ADDR_SIZE:0] r_wbin;
  logic               w_inc;
  logic [ADDR_SIZE:0] w_wbinnext;
  logic [ADDR_SIZE:0] w_graynext;
  logic               w_fullnext;

  // A write is only taken while the registered full flag is clear.
  assign w_inc      = winc & ~wFull;
  assign w_wbinnext = r_wbin + {{ADDR_SIZE{1'b0}}, w_inc};
  assign w_graynext = (w_wbinnext >> 1) ^ w_wbinnext;
  assign waddr      = r_wbin[ADDR_SIZE-1:0];

  // Full when the next write Gray pointer is one lap ahead of the read pointer.
  assign w_fullnext = (w_graynext == {~rptr_s[ADDR_SIZE:ADDR_SIZE-1], rptr_s[ADDR_SIZE-2:0]});

  // Pointer, full and sticky overflow registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wbin <= '0;
      wptr   <= '0;
      wFull  <= 1'b0;
      wOvf   <= 1'b0;
    end else begin
      r_wbin <= w_wbinnext;
      wptr   <= w_graynext;
      wFull  <= w_fullnext;
      if (winc && wFull) wOvf <= 1'b1;
    end
  end

`ifdef WPTR_LEVEL_EN
  localparam logic [ADDR_SIZE:0] AF_TH = (ADDR_SIZE+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDR_SIZE:0] w_rbin_s;
  logic [ADDR_SIZE:0] w_levnext;

  // Gray-to-binary conversion of the synchronized read pointer.
  always_comb begin
    w_rbin_s            = '0;
    w_rbin_s[ADDR_SIZE] = rptr_s[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--)
      w_rbin_s[i] = w_rbin_s[i+1] ^ rptr_s[i];
  end

  // Modular subtraction yields 0..DEPTH for any legal pointer pair.
  assign w_levnext = w_wbinnext - w_rbin_s;

  // Registered level and almost-full.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wLevel <= '0;
      wAFull <= 1'b0;
    end else begin
      wLevel <= w_levnext;
      wAFull <= (w_levnext >= AF_TH);
    end
  end
`else
  assign wLevel = '0;
  assign wAFull = 1'b0;
`endif

endmodule
